// File: rtl/lsu_pkg.sv
// Shared state/encoding types and byte-lane helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  // Unlisted encodings fall through to word access.
  function automatic lsu_size_e f_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] f_store_be(input logic [2:0] funct3, input logic [1:0] off);
    case (f_size(funct3))
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_store_wdata(input logic [2:0] funct3, input logic [XLEN-1:0] wd);
    case (f_size(funct3))
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_load_extract(input logic [2:0] funct3, input logic [1:0] off,
                                                      input logic [XLEN-1:0] rdata);
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = rdata[{off, 3'b000} +: 8];
    h16 = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    return {{24{b8[7]}}, b8};
      F3_BU:   return {24'd0, b8};
      F3_H:    return {{16{h16[15]}}, h16};
      F3_HU:   return {16'd0, h16};
      default: return rdata;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (f_size(funct3))
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Valid/ready request and single-cycle response channel between the LSU and data memory.
interface lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [BE_W-1:0]   mem_req_be;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane replication/enables and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      i_st_funct3,
  input  logic [1:0]      i_st_off,
  input  logic [XLEN-1:0] i_st_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [BE_W-1:0] o_st_be_c,
  output logic [XLEN-1:0] o_st_wdata_c,
  output logic [XLEN-1:0] o_ld_data_c
);
  assign o_st_be_c    = f_store_be(i_st_funct3, i_st_off);
  assign o_st_wdata_c = f_store_wdata(i_st_funct3, i_st_wdata);
  assign o_ld_data_c  = f_load_extract(i_ld_funct3, i_ld_off, i_ld_rdata);
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: issues word requests to a multi-cycle data memory and stalls the pipeline until done.
// Optional LSU_MISALIGN_TRAP_EN: misaligned h/w accesses skip the memory and report LsuErrM instead.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            LsuErrM,
  lsu_mem_if.master       mem
);
  localparam int unsigned CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

  lsu_state_e      r_state;
  logic [2:0]      r_ld_funct3;
  logic [1:0]      r_ld_off;
  logic [CNT_W-1:0] r_cnt;

  logic            w_op;
  logic            w_trap;
  logic            w_timeout;
  logic [BE_W-1:0] w_st_be;
  logic [XLEN-1:0] w_st_wdata;
  logic [XLEN-1:0] w_ld_data;

  assign w_op      = MemReadM | MemWriteM;
  assign w_timeout = (RESP_TIMEOUT != 0) && (r_cnt == CNT_W'(RESP_TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = f_misaligned(Funct3M, ALUResultM[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // Reset gating keeps the pipeline free-running while reset is held.
  assign StallM = reset & (((r_state == IDLE) & w_op) | (r_state == REQ) | (r_state == RESP));

  lsu_align u_align (
    .i_st_funct3  (Funct3M),
    .i_st_off     (ALUResultM[1:0]),
    .i_st_wdata   (WriteDataM),
    .i_ld_funct3  (r_ld_funct3),
    .i_ld_off     (r_ld_off),
    .i_ld_rdata   (mem.mem_rsp_rdata),
    .o_st_be_c    (w_st_be),
    .o_st_wdata_c (w_st_wdata),
    .o_ld_data_c  (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_ld_funct3       <= 3'd0;
      r_ld_off          <= 2'd0;
      r_cnt             <= '0;
      ReadDataM         <= '0;
      LsuErrM           <= 1'b0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_we    <= 1'b0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_wdata <= '0;
      mem.mem_req_be    <= '0;
    end else begin
      LsuErrM <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_op) begin
            r_ld_funct3 <= Funct3M;
            r_ld_off    <= ALUResultM[1:0];
            if (w_trap) begin
              LsuErrM <= 1'b1;
              r_state <= DONE;
            end else begin
              mem.mem_req_valid <= 1'b1;
              mem.mem_req_we    <= MemWriteM;
              mem.mem_req_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
              mem.mem_req_be    <= MemWriteM ? w_st_be : 4'b1111;
              mem.mem_req_wdata <= MemWriteM ? w_st_wdata : '0;
              r_state           <= REQ;
            end
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            r_cnt             <= '0;
            r_state           <= mem.mem_req_we ? DONE : RESP;
          end
        end
        RESP: begin
          if (mem.mem_rsp_valid) begin
            ReadDataM <= w_ld_data;
            r_state   <= DONE;
          end else if (w_timeout) begin
            ReadDataM <= '0;
            LsuErrM   <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, randomized memory latencies.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, LsuErrM;

  lsu_mem_if #(.ADDR_W(32)) mem_if ();

  load_store_unit #(.ADDR_W(32), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .LsuErrM(LsuErrM), .mem(mem_if)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { int stall; logic err; logic [31:0] rdata; } done_t;
  typedef struct { int rd; int pd; } dly_t;

  req_t  q_req[$];
  done_t q_done[$];
  dly_t  q_dly[$];

  logic [7:0]  bmem [256];
  logic [31:0] wmem [64];
  logic [31:0] last_rd;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int op_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (StallM && n < 40);
    if (StallM) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: StallM still 1 after %0d cycles", n);
    end
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  // Model: byte-addressed memory; effective address rounds down to the access size.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int rd, input int pd);
    int sz;
    logic [31:0] ea, v;
    logic trap;
    req_t r;
    done_t d;
    dly_t dl;
    sz = op_size(f3);
    ea = addr & ~(32'(sz) - 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (ea != addr);
`else
    trap = 1'b0;
`endif
    d.err = 1'b0;
    d.rdata = last_rd;
    if (trap) begin
      d.err = 1'b1;
      d.stall = 1;
    end else begin
      r.we = st;
      r.addr = addr & ~32'd3;
      if (st) begin
        r.be = 4'(((1 << sz) - 1) << ea[1:0]);
        r.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        for (int i = 0; i < sz; i++) bmem[8'(ea + 32'(i))] = wd[8*i +: 8];
        d.stall = rd + 2;
      end else begin
        r.be = 4'hF;
        r.wdata = 32'd0;
        v = 32'd0;
        if (pd >= int'(TO)) begin
          d.err = 1'b1;
          d.stall = rd + 2 + int'(TO);
        end else begin
          for (int i = 0; i < sz; i++) v = v | (32'(bmem[8'(ea + 32'(i))]) << (8 * i));
          if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
          if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
          d.stall = rd + 3 + pd;
        end
        last_rd = v;
        d.rdata = v;
      end
      dl.rd = rd;
      dl.pd = pd;
      q_req.push_back(r);
      q_dly.push_back(dl);
    end
    q_done.push_back(d);
    MemReadM   = !st;
    MemWriteM  = st;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    wait_done();
  endtask

  // Memory responder: applies the bench-chosen ready/response delays and holds the word array.
  initial begin : responder
    dly_t dl;
    logic [31:0] a, wd_s;
    logic [3:0]  be_s;
    logic        we_s;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = 32'd0;
    forever begin
      while (!mem_if.mem_req_valid) tick();
      if (q_dly.size() == 0) begin
        dl.rd = 0;
        dl.pd = 0;
      end else dl = q_dly.pop_front();
      repeat (dl.rd) tick();
      mem_if.mem_req_ready = 1'b1;
      a    = mem_if.mem_req_addr;
      we_s = mem_if.mem_req_we;
      be_s = mem_if.mem_req_be;
      wd_s = mem_if.mem_req_wdata;
      tick();
      mem_if.mem_req_ready = 1'b0;
      if (we_s) begin
        for (int k = 0; k < 4; k++) if (be_s[k]) wmem[a[7:2]][8*k +: 8] = wd_s[8*k +: 8];
      end else begin
        repeat (dl.pd) tick();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = wmem[a[7:2]];
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_rdata = $urandom();
      end
    end
  end

  // Monitor: compares request fields every REQ cycle and the completion in each DONE cycle.
  initial begin : monitor
    int stall_cnt;
    logic prev_stall;
    done_t d;
    stall_cnt = 0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_valid", 32'(mem_if.mem_req_valid), 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_err", 32'(LsuErrM), 32'd0);
        stall_cnt = 0;
        prev_stall = 1'b0;
      end else begin
        if (mem_if.mem_req_valid) begin
          if (q_req.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_req: addr %08h with no request expected", mem_if.mem_req_addr);
          end else begin
            check("req_we", 32'(mem_if.mem_req_we), 32'(q_req[0].we));
            check("req_addr", mem_if.mem_req_addr, q_req[0].addr);
            check("req_be", 32'(mem_if.mem_req_be), 32'(q_req[0].be));
            if (q_req[0].we) check("req_wdata", mem_if.mem_req_wdata, q_req[0].wdata);
            if (mem_if.mem_req_ready) void'(q_req.pop_front());
          end
        end
        if (StallM) stall_cnt++;
        else if (prev_stall) begin
          if (q_done.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done: completion with none expected");
          end else begin
            d = q_done.pop_front();
            check("stall_cycles", 32'(stall_cnt), 32'(d.stall));
            check("done_err", 32'(LsuErrM), 32'(d.err));
            check("done_rdata", ReadDataM, d.rdata);
          end
          stall_cnt = 0;
        end else check("idle_err", 32'(LsuErrM), 32'd0);
        prev_stall = StallM;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    req_t r;
    dly_t dl;
    logic st;
    logic [2:0] f3;
    int pd;
    for (int i = 0; i < 256; i++) bmem[i] = 8'(i * 37 + 11);
    for (int w = 0; w < 64; w++) wmem[w] = {bmem[4*w+3], bmem[4*w+2], bmem[4*w+1], bmem[4*w]};
    last_rd = 32'd0;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0; ALUResultM = 32'd0; WriteDataM = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
    do_op(1'b1, 3'b010, 32'h100, 32'h80FF1234, 0, 0);
    do_op(1'b0, 3'b000, 32'h103, 32'd0, 0, 0);
    do_op(1'b0, 3'b100, 32'h103, 32'd0, 1, 0);
    do_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5, 0);
    do_op(1'b0, 3'b010, 32'h200, 32'd0, 0, 2);
    do_op(1'b0, 3'b010, 32'h1F0, 32'd0, 1, int'(TO));
    do_op(1'b1, 3'b010, 32'h104, 32'h12345678, 0, 0);
    do_op(1'b0, 3'b001, 32'h101, 32'd0, 0, 0);
    do_op(1'b1, 3'b001, 32'h107, 32'h00005AA5, 0, 0);
    do_op(1'b0, 3'b010, 32'h106, 32'd0, 2, 1);
    do_op(1'b0, 3'b101, 32'h106, 32'd0, 0, 3);
    do_op(1'b1, 3'b011, 32'h108, 32'hCAFEF00D, 1, 0);
    do_op(1'b0, 3'b110, 32'h108, 32'd0, 0, 0);

    // Reset asserted while the load waits in RESP; its response lands after reset.
    tick();
    r.we = 1'b0; r.addr = 32'h140; r.be = 4'hF; r.wdata = 32'd0;
    dl.rd = 0; dl.pd = 2;
    q_req.push_back(r);
    q_dly.push_back(dl);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h140;
    tick();
    tick();
    tick();
    reset = 1'b0;
    MemReadM = 1'b0;
    last_rd = 32'd0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    do_op(1'b0, 3'b010, 32'h140, 32'd0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 6))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          4: f3 = 3'b101; 5: f3 = 3'b110; default: f3 = 3'b111;
        endcase
      end
      pd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 1)) : int'($urandom_range(0, TO - 1));
      do_op(st, f3, 32'h100 + 32'($urandom_range(0, 255)), $urandom(), int'($urandom_range(0, 3)), pd);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (10) tick();
    check("q_req_empty", 32'(q_req.size()), 32'd0);
    check("q_done_empty", 32'(q_done.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
